weight_load_ctrl_1x8: RTL and testbench
=======================================

# weight_load_ctrl_1x8

Write-side controller for the 1x8 weight buffer. It accepts a valid/ready stream of 72-bit weight words (one 3x3 kernel of 8-bit weights per word) from the DDR/DMA read path. It steers each word into one of eight weight RAM banks (one bank per output channel) by generating per-bank write addresses and write enables. Loading is bank-major: all words of bank 0, then bank 1, and so on. A done pulse tells the layer scheduler that the compute stage may start reading.

## Interface
- DEPTH, 512, words per bank RAM
- ADDR_BIT, 9, bank address width; 2^ADDR_BIT >= DEPTH
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches word_last/bank_last, begins a load
- word_last  in  ADDR_BIT  words per bank minus 1 (0 means 1 word)
- bank_last  in  3  banks to fill minus 1 (0 means bank 0 only; 7 means all 8)
- s_valid  in  1  input word valid
- s_ready  out  1  controller can accept a word
- s_data  in  72  input weight word
- write_addr_0..write_addr_7  out  ADDR_BIT each  bank write address; all eight carry the same value
- write_en_0..write_en_7  out  1 each  bank write strobe; at most one high per cycle
- weight_in  out  72  write data shared by all banks
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at load completion
- checksum  out  72  running XOR of accepted words (see Configuration)

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - start=1 latches word_last into wl_r and bank_last into bl_r.
  - Clears word_cnt and bank_cnt, then moves to LOAD.
- LOAD:
  - s_ready=1.
  - A beat is accepted when s_valid & s_ready.
  - On each accepted beat, register: weight_in <= s_data; write_addr_* <= word_cnt; write_en_{bank_cnt} <= 1.
  - If word_cnt==wl_r: word_cnt wraps to 0 and bank_cnt increments.
  - Otherwise word_cnt increments.
  - If word_cnt==wl_r and bank_cnt==bl_r, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start is ignored outside IDLE and has no effect on a load in progress.
- Banks above bl_r are never written.
- s_data is ignored when s_valid=0 or s_ready=0. Bubbles on s_valid stall the counters.
- word_cnt never exceeds wl_r. Values of wl_r >= DEPTH are a caller error; the controller still wraps at wl_r.
- rst mid-load:
  - Returns to IDLE on the next edge and abandons the load; done does not pulse.
  - The partial RAM contents are undefined to consumers.

## Timing
- Reset values:
  - s_ready=0, busy=0, done=0.
  - All write_en_*=0, all write_addr_*=0, weight_in=0, checksum=0.
- start at edge t gives s_ready=1 and busy=1 from cycle t+1.
- Beat accepted at edge t produces the write_en/addr/data pulse during cycle t+1, so the RAM writes at edge t+1. Latency is 1 cycle.
- write_en_* is high only in the cycle after an accepted beat. weight_in and write_addr_* hold their last values otherwise.
- Last beat accepted at edge t:
  - s_ready drops in cycle t+1; the final write_en is also in cycle t+1.
  - done=1 in cycle t+2; busy drops in cycle t+3.
- Back-to-back loads: the earliest next start is sampled in the done cycle+1 (first IDLE cycle).
- Total for an unstalled load: (wl_r+1)*(bl_r+1) beats plus 3 cycles from start to done.

## Configuration
- WEIGHT_LOAD_CHECKSUM_EN defined:
  - checksum clears to 0 on an accepted start.
  - checksum updates checksum ^= s_data on every accepted beat, registered so that it is final in the done cycle.
  - checksum holds its value in IDLE.
- Undefined: checksum is tied to 0 and no checksum register is synthesized.

## Test plan
- Full load: start with word_last=3, bank_last=7, and 32 consecutive beats of data 0..31.
  - Expect word k of bank b, data 4b+k, written at addr k with write_en_b only.
  - done occurs 2 cycles after the last beat.
- Partial banks: word_last=0, bank_last=2, data A,B,C.
  - Expect write_en_0/1/2 at addr 0 with A/B/C.
  - write_en_3..7 never assert; s_ready=0 after the 3rd beat.
- Stalls: same as the full-load case with s_valid toggled 1,0,0,1,...
  - Expect write order and contents identical to the full-load case, with no write_en during bubbles.
- Start while busy: pulse start with word_last=0 mid-load.
  - Expect the original load to finish unchanged with a single done.
- Reset mid-load: assert rst after 5 of 16 beats.
  - Expect all outputs at reset values next cycle, no done pulse, s_ready=0.
  - A new start then loads correctly.
- Checksum (macro defined): beats 0x..01, 0x..03, 0x..06 (72-bit).
  - Expect checksum=0x..04 in the done cycle; with the macro undefined, checksum stays 0.

Source files
------------

// File: rtl/weight_load_ctrl_1x8_if.sv
// Weight word stream from the DMA read path into the weight load controller.
// Latency: none, wiring only.
// Backpressure: a word moves only on a cycle where s_valid and s_ready are both high.
interface weight_load_ctrl_1x8_if;
    logic        s_valid;
    logic        s_ready;
    logic [71:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/weight_load_ctrl_1x8.sv
// Bank-major write controller: steers 72-bit kernel words into eight weight RAM banks.
// Latency: 1 cycle from an accepted beat to its write_en/write_addr/weight_in pulse.
// Backpressure: s_ready is high only during LOAD; bubbles on s_valid stall the counters.
// Optional feature: define WEIGHT_LOAD_CHECKSUM_EN for a running XOR checksum of accepted words.
module weight_load_ctrl_1x8 #(
    parameter int DEPTH    = 512,
    parameter int ADDR_BIT = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_BIT-1:0] word_last,
    input  logic [2:0]          bank_last,
    weight_load_ctrl_1x8_if.slave stream,
    output logic [ADDR_BIT-1:0] write_addr_0,
    output logic [ADDR_BIT-1:0] write_addr_1,
    output logic [ADDR_BIT-1:0] write_addr_2,
    output logic [ADDR_BIT-1:0] write_addr_3,
    output logic [ADDR_BIT-1:0] write_addr_4,
    output logic [ADDR_BIT-1:0] write_addr_5,
    output logic [ADDR_BIT-1:0] write_addr_6,
    output logic [ADDR_BIT-1:0] write_addr_7,
    output logic                write_en_0,
    output logic                write_en_1,
    output logic                write_en_2,
    output logic                write_en_3,
    output logic                write_en_4,
    output logic                write_en_5,
    output logic                write_en_6,
    output logic                write_en_7,
    output logic [71:0]         weight_in,
    output logic                busy,
    output logic                done,
    output logic [71:0]         checksum
);

    localparam longint ADDR_SPAN = longint'(1) << ADDR_BIT;

    // The address field must be able to reach every word of a bank.
    if (ADDR_SPAN < longint'(DEPTH)) begin : g_depth_check
        $error("ADDR_BIT too narrow for DEPTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_BIT-1:0] wl_r;
    logic [2:0]          bl_r;
    logic [ADDR_BIT-1:0] word_cnt;
    logic [2:0]          bank_cnt;
    logic                s_ready_r;
    logic                busy_r;
    logic                done_r;
    logic [7:0]          we_r;
    logic [ADDR_BIT-1:0] addr_r;
    logic [71:0]         weight_r;
    logic                beat;
    logic                start_acc;

    // s_ready_r is only ever high in LOAD, so it doubles as the load qualifier.
    assign beat      = stream.s_valid & s_ready_r;
    assign start_acc = (state == IDLE) & start;

    // Control FSM plus the registered write strobe/address/data for the banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wl_r      <= '0;
            bl_r      <= '0;
            word_cnt  <= '0;
            bank_cnt  <= '0;
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            we_r      <= '0;
            addr_r    <= '0;
            weight_r  <= '0;
        end else begin
            we_r <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        wl_r      <= word_last;
                        bl_r      <= bank_last;
                        word_cnt  <= '0;
                        bank_cnt  <= '0;
                        s_ready_r <= 1'b1;
                        busy_r    <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        weight_r       <= stream.s_data;
                        addr_r         <= word_cnt;
                        we_r[bank_cnt] <= 1'b1;
                        if (word_cnt == wl_r) begin
                            word_cnt <= '0;
                            bank_cnt <= bank_cnt + 3'd1;
                            if (bank_cnt == bl_r) begin
                                s_ready_r <= 1'b0;
                                state     <= DONE;
                            end
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // First DONE cycle carries the final write; done pulses in the second.
                    if (!done_r) begin
                        done_r <= 1'b1;
                    end else begin
                        done_r <= 1'b0;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef WEIGHT_LOAD_CHECKSUM_EN
    logic [71:0] checksum_r;

    // Running XOR of accepted words; cleared by an accepted start, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_r <= '0;
        end else if (start_acc) begin
            checksum_r <= '0;
        end else if (beat) begin
            checksum_r <= checksum_r ^ stream.s_data;
        end
    end

    assign checksum = checksum_r;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign checksum         = '0;
`endif

    assign stream.s_ready = s_ready_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign weight_in      = weight_r;

    assign write_addr_0 = addr_r;
    assign write_addr_1 = addr_r;
    assign write_addr_2 = addr_r;
    assign write_addr_3 = addr_r;
    assign write_addr_4 = addr_r;
    assign write_addr_5 = addr_r;
    assign write_addr_6 = addr_r;
    assign write_addr_7 = addr_r;

    assign write_en_0 = we_r[0];
    assign write_en_1 = we_r[1];
    assign write_en_2 = we_r[2];
    assign write_en_3 = we_r[3];
    assign write_en_4 = we_r[4];
    assign write_en_5 = we_r[5];
    assign write_en_6 = we_r[6];
    assign write_en_7 = we_r[7];

endmodule

// File: tb/tb_weight_load_ctrl_1x8.sv
// Directed bench for the 1x8 weight load controller.
// Latency: checks outputs 1 ns after each rising edge.
// Backpressure: exercises s_valid bubbles and words offered while s_ready is low.
module tb_weight_load_ctrl_1x8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  word_last;
    logic [2:0]  bank_last;
    logic [8:0]  write_addr_0, write_addr_1, write_addr_2, write_addr_3;
    logic [8:0]  write_addr_4, write_addr_5, write_addr_6, write_addr_7;
    logic        write_en_0, write_en_1, write_en_2, write_en_3;
    logic        write_en_4, write_en_5, write_en_6, write_en_7;
    logic [71:0] weight_in;
    logic        busy;
    logic        done;
    logic [71:0] checksum;

    weight_load_ctrl_1x8_if bus ();

    weight_load_ctrl_1x8 #(.DEPTH(512), .ADDR_BIT(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .word_last    (word_last),
        .bank_last    (bank_last),
        .stream       (bus.slave),
        .write_addr_0 (write_addr_0),
        .write_addr_1 (write_addr_1),
        .write_addr_2 (write_addr_2),
        .write_addr_3 (write_addr_3),
        .write_addr_4 (write_addr_4),
        .write_addr_5 (write_addr_5),
        .write_addr_6 (write_addr_6),
        .write_addr_7 (write_addr_7),
        .write_en_0   (write_en_0),
        .write_en_1   (write_en_1),
        .write_en_2   (write_en_2),
        .write_en_3   (write_en_3),
        .write_en_4   (write_en_4),
        .write_en_5   (write_en_5),
        .write_en_6   (write_en_6),
        .write_en_7   (write_en_7),
        .weight_in    (weight_in),
        .busy         (busy),
        .done         (done),
        .checksum     (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] we_v;
    logic [8:0] wa [8];
    assign we_v  = {write_en_7, write_en_6, write_en_5, write_en_4,
                    write_en_3, write_en_2, write_en_1, write_en_0};
    assign wa[0] = write_addr_0;
    assign wa[1] = write_addr_1;
    assign wa[2] = write_addr_2;
    assign wa[3] = write_addr_3;
    assign wa[4] = write_addr_4;
    assign wa[5] = write_addr_5;
    assign wa[6] = write_addr_6;
    assign wa[7] = write_addr_7;

    int          pass_cnt;
    int          total_cnt;
    logic [71:0] data_tab [64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        total_cnt++;
        if (bus.s_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || we_v !== 8'h00 ||
            weight_in !== 72'h0 || checksum !== 72'h0) begin
            $display("FAIL %s: s_ready=%b busy=%b done=%b we=%b weight_in=%h checksum=%h, required all zero",
                     tag, bus.s_ready, busy, done, we_v, weight_in, checksum);
        end else begin
            pass_cnt++;
        end
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (wa[i] !== 9'd0) $display("FAIL %s addr%0d: got %0d required 0", tag, i, wa[i]);
            else pass_cnt++;
        end
    endtask

    // One complete load; words come from data_tab. stall: offer words in a 1,0,0 pattern.
    // mid_start: pulse start with word_last=0 after two accepted words.
    task automatic run_load(input int wl, input int bl, input bit stall, input bit mid_start,
                            input string tag, output logic [71:0] csum_at_done);
        int          total;
        int          sent;
        int          cyc;
        int          bank;
        int          word;
        bit          acc;
        logic [71:0] x;
        logic [71:0] exp_csum;
        total = (wl + 1) * (bl + 1);
        sent  = 0;
        cyc   = 0;
        x     = '0;
        word_last = 9'(wl);
        bank_last = 3'(bl);
        start     = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if (bus.s_ready !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL %s start: s_ready=%b busy=%b required 1 1", tag, bus.s_ready, busy);
        end else begin
            pass_cnt++;
        end
        while (sent < total && cyc < 2000) begin
            bus.s_valid = stall ? ((cyc % 3) == 0) : 1'b1;
            bus.s_data  = bus.s_valid ? data_tab[sent] : (72'hF0F0_F0F0_F0F0_F0F0_F0 ^ 72'(cyc));
            if (mid_start && sent == 2) begin
                start     = 1'b1;
                word_last = 9'd0;
            end
            acc = bus.s_valid && bus.s_ready;
            tick();
            start = 1'b0;
            if (acc) begin
                bank = sent / (wl + 1);
                word = sent % (wl + 1);
                total_cnt++;
                if (we_v !== (8'd1 << bank) || weight_in !== data_tab[sent] || wa[bank] !== 9'(word)) begin
                    $display("FAIL %s write%0d: we=%b addr=%0d data=%h, required we=%b addr=%0d data=%h",
                             tag, sent, we_v, wa[bank], weight_in, 8'd1 << bank, word, data_tab[sent]);
                end else begin
                    pass_cnt++;
                end
                x = x ^ data_tab[sent];
                sent++;
            end else begin
                total_cnt++;
                if (we_v !== 8'h00) $display("FAIL %s bubble: we=%b required 00000000", tag, we_v);
                else pass_cnt++;
            end
            if (sent < total) begin
                total_cnt++;
                if (bus.s_ready !== 1'b1 || done !== 1'b0) begin
                    $display("FAIL %s mid: s_ready=%b done=%b required 1 0", tag, bus.s_ready, done);
                end else begin
                    pass_cnt++;
                end
            end
            cyc++;
        end
        if (sent < total) begin
            total_cnt++;
            $display("FAIL %s timeout: accepted %0d words required %0d", tag, sent, total);
        end
        // Cycle after the last beat: s_ready low, done not yet, still busy.
        total_cnt++;
        if (bus.s_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL %s last+1: s_ready=%b done=%b busy=%b required 0 0 1",
                     tag, bus.s_ready, done, busy);
        end else begin
            pass_cnt++;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = 72'hDE_ADBE_EFDE_ADBE_EFDE;
        tick();
        bus.s_valid = 1'b0;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
        exp_csum = x;
`else
        exp_csum = 72'h0;
`endif
        csum_at_done = checksum;
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b1 || we_v !== 8'h00 || checksum !== exp_csum) begin
            $display("FAIL %s done: done=%b busy=%b we=%b checksum=%h required 1 1 00000000 %h",
                     tag, done, busy, we_v, checksum, exp_csum);
        end else begin
            pass_cnt++;
        end
        tick();
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || bus.s_ready !== 1'b0) begin
            $display("FAIL %s idle: done=%b busy=%b s_ready=%b required 0 0 0", tag, done, busy, bus.s_ready);
        end else begin
            pass_cnt++;
        end
        tick();
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || we_v !== 8'h00) begin
            $display("FAIL %s idle2: done=%b busy=%b we=%b required 0 0 00000000", tag, done, busy, we_v);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check_reset_outputs("reset_release");
    endtask

    task automatic test_full_load();
        logic [71:0] c;
        for (int i = 0; i < 32; i++) data_tab[i] = 72'(i);
        run_load(3, 7, 1'b0, 1'b0, "full", c);
    endtask

    task automatic test_partial_banks();
        logic [71:0] c;
        data_tab[0] = 72'hAA_1111_2222_3333_4444;
        data_tab[1] = 72'hBB_5555_6666_7777_8888;
        data_tab[2] = 72'hCC_9999_AAAA_BBBB_CCCC;
        run_load(0, 2, 1'b0, 1'b0, "partial", c);
    endtask

    task automatic test_stalls();
        logic [71:0] c;
        for (int i = 0; i < 32; i++) data_tab[i] = 72'(i);
        run_load(3, 7, 1'b1, 1'b0, "stall", c);
    endtask

    task automatic test_start_while_busy();
        logic [71:0] c;
        for (int i = 0; i < 6; i++) data_tab[i] = 72'h55_0000_0000_0000_0000 | 72'(i * 7);
        run_load(2, 1, 1'b0, 1'b1, "start_busy", c);
    endtask

    task automatic test_reset_mid_load();
        logic [71:0] c;
        for (int i = 0; i < 16; i++) data_tab[i] = 72'h12_3456_0000_0000_0000 | 72'(i);
        word_last   = 9'd15;
        bank_last   = 3'd0;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.s_data = data_tab[i];
            tick();
        end
        rst        = 1'b1;
        bus.s_data = data_tab[5];
        tick();
        check_reset_outputs("rst_mid");
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++;
            if (done !== 1'b0 || bus.s_ready !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL rst_after%0d: done=%b s_ready=%b busy=%b required 0 0 0",
                         i, done, bus.s_ready, busy);
            end else begin
                pass_cnt++;
            end
        end
        for (int i = 0; i < 4; i++) data_tab[i] = 72'h77_0000_0000_0000_0000 | 72'(i + 40);
        run_load(1, 1, 1'b0, 1'b0, "rst_recover", c);
    endtask

    task automatic test_checksum();
        logic [71:0] c;
        logic [71:0] exp;
        data_tab[0] = 72'h01;
        data_tab[1] = 72'h03;
        data_tab[2] = 72'h06;
        run_load(2, 0, 1'b0, 1'b0, "checksum", c);
`ifdef WEIGHT_LOAD_CHECKSUM_EN
        exp = 72'h04;
`else
        exp = 72'h00;
`endif
        total_cnt++;
        if (c !== exp) $display("FAIL checksum_value: got %h required %h", c, exp);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [71:0] c;
        data_tab[0] = 72'h9A;
        data_tab[1] = 72'h3C;
        run_load(0, 1, 1'b0, 1'b0, "b2b_a", c);
        data_tab[0] = 72'hE1;
        data_tab[1] = 72'h2F;
        run_load(1, 0, 1'b0, 1'b0, "b2b_b", c);
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        rst         = 1'b1;
        start       = 1'b0;
        word_last   = '0;
        bank_last   = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        test_reset();
        test_full_load();
        test_partial_banks();
        test_stalls();
        test_start_while_busy();
        test_reset_mid_load();
        test_checksum();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
